// File: rtl/div_pkg.sv
// Parameters and types shared between the divider and its result-formatting stage.
package div_pkg;

  localparam int RESULT_W   = 17;
  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int DIGITS     = 5;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Add-3 correction so the following left shift carries into the next digit
  always_comb begin
    if (digit_in >= 4'd5) begin
      digit_out = digit_in + 4'd3;
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/div_result_bcd.sv
// Converts signed divider results into sign + packed BCD magnitude, one bit per cycle,
// with a single-entry pending buffer since the divider cannot be stalled.
module div_result_bcd #(
  parameter int RESULT_W = div_pkg::RESULT_W,
  parameter int DIGITS   = div_pkg::DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_input,
  input  logic [RESULT_W-1:0]   result_in,
  input  logic                  mode_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  mode_out,
  output logic                  valid_output,
  output logic                  busy,
  output logic                  drop_flag
);
  import div_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(RESULT_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RESULT_W - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RESULT_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 conv_sign_q, conv_sign_d;
  logic                 conv_mode_q, conv_mode_d;
  logic                 pend_full_q, pend_full_d;
  logic [RESULT_W-1:0]  pend_mag_q, pend_mag_d;
  logic                 pend_sign_q, pend_sign_d;
  logic                 pend_mode_q, pend_mode_d;
  logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;
  logic                 sign_out_q, sign_out_d;
  logic                 mode_out_q, mode_out_d;
  logic                 valid_q, valid_d;
  logic                 drop_q, drop_d;

  logic [RESULT_W-1:0]  in_mag_s;
  logic [BCD_W-1:0]     bcd_adj_s;
  logic [BCD_W-1:0]     bcd_shift_s;
  logic [RESULT_W-1:0]  sh_shift_s;

  // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1) without overflow in W unsigned bits
  assign in_mag_s = result_in[RESULT_W-1] ? (~result_in + RESULT_W'(1)) : result_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (bcd_q[4*g +: 4]),
      .digit_out (bcd_adj_s[4*g +: 4])
    );
  end

  assign bcd_shift_s = {bcd_adj_s[BCD_W-2:0], sh_q[RESULT_W-1]};
  assign sh_shift_s  = {sh_q[RESULT_W-2:0], 1'b0};

  // Next-state, buffering and output-register update logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    conv_sign_d = conv_sign_q;
    conv_mode_d = conv_mode_q;
    pend_full_d = pend_full_q;
    pend_mag_d  = pend_mag_q;
    pend_sign_d = pend_sign_q;
    pend_mode_d = pend_mode_q;
    bcd_out_d   = bcd_out_q;
    sign_out_d  = sign_out_q;
    mode_out_d  = mode_out_q;
    valid_d     = 1'b0;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          // Pending result has priority; a simultaneous arrival refills the buffer
          sh_d        = pend_mag_q;
          conv_sign_d = pend_sign_q;
          conv_mode_d = pend_mode_q;
          bcd_d       = '0;
          cnt_d       = '0;
          state_d     = CONV;
          if (valid_input) begin
            pend_full_d = 1'b1;
            pend_mag_d  = in_mag_s;
            pend_sign_d = result_in[RESULT_W-1];
            pend_mode_d = mode_in;
          end else begin
            pend_full_d = 1'b0;
          end
        end else if (valid_input) begin
          sh_d        = in_mag_s;
          conv_sign_d = result_in[RESULT_W-1];
          conv_mode_d = mode_in;
          bcd_d       = '0;
          cnt_d       = '0;
          state_d     = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        bcd_d = bcd_shift_s;
        sh_d  = sh_shift_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bcd_out_d  = bcd_shift_s;
          sign_out_d = conv_sign_q;
          mode_out_d = conv_mode_q;
          valid_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = CONV;
        end
        if (valid_input) begin
          if (pend_full_q) begin
            drop_d = 1'b1;
          end else begin
            pend_full_d = 1'b1;
            pend_mag_d  = in_mag_s;
            pend_sign_d = result_in[RESULT_W-1];
            pend_mode_d = mode_in;
          end
        end else begin
          pend_full_d = pend_full_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      bcd_q       <= '0;
      conv_sign_q <= 1'b0;
      conv_mode_q <= 1'b0;
      pend_full_q <= 1'b0;
      pend_mag_q  <= '0;
      pend_sign_q <= 1'b0;
      pend_mode_q <= 1'b0;
      bcd_out_q   <= '0;
      sign_out_q  <= 1'b0;
      mode_out_q  <= 1'b0;
      valid_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      bcd_q       <= bcd_d;
      conv_sign_q <= conv_sign_d;
      conv_mode_q <= conv_mode_d;
      pend_full_q <= pend_full_d;
      pend_mag_q  <= pend_mag_d;
      pend_sign_q <= pend_sign_d;
      pend_mode_q <= pend_mode_d;
      bcd_out_q   <= bcd_out_d;
      sign_out_q  <= sign_out_d;
      mode_out_q  <= mode_out_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign bcd_out      = bcd_out_q;
  assign sign_out     = sign_out_q;
  assign mode_out     = mode_out_q;
  assign valid_output = valid_q;
  assign busy         = (state_q == CONV);
  assign drop_flag    = drop_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: cycle-indexed strobe tables, pulses logged and
// compared against hand-computed BCD values and cycle positions.
module tb_div_result_bcd;

  logic        clk;
  logic        reset;
  logic        valid_input;
  logic [16:0] result_in;
  logic        mode_in;
  logic [19:0] bcd_out;
  logic        sign_out;
  logic        mode_out;
  logic        valid_output;
  logic        busy;
  logic        drop_flag;

  div_result_bcd dut (
    .clk          (clk),
    .reset        (reset),
    .valid_input  (valid_input),
    .result_in    (result_in),
    .mode_in      (mode_in),
    .bcd_out      (bcd_out),
    .sign_out     (sign_out),
    .mode_out     (mode_out),
    .valid_output (valid_output),
    .busy         (busy),
    .drop_flag    (drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [19:0] bcd;
    logic        s;
    logic        m;
  } pulse_t;

  pulse_t      pq[$];
  logic        stim_v   [0:63];
  logic [16:0] stim_val [0:63];
  logic        stim_m   [0:63];
  logic        busy_tr  [0:63];
  logic        drop_tr  [0:63];
  int          n_checks;
  int          n_fail;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      stim_v[i]   = 1'b0;
      stim_val[i] = 17'd0;
      stim_m[i]   = 1'b0;
    end
    pq.delete();
  endtask

  task automatic add_stim(input int n, input int value, input logic m);
    stim_v[n]   = 1'b1;
    stim_val[n] = 17'(value);
    stim_m[n]   = m;
  endtask

  // At negedge n: log outputs produced by edge n-1, then drive inputs for edge n
  task automatic run(input int ncyc);
    pulse_t p;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      busy_tr[n] = busy;
      drop_tr[n] = drop_flag;
      if (valid_output) begin
        p.cyc = n; p.bcd = bcd_out; p.s = sign_out; p.m = mode_out;
        pq.push_back(p);
      end
      valid_input = stim_v[n];
      result_in   = stim_val[n];
      mode_in     = stim_m[n];
    end
    @(negedge clk);
    valid_input = 1'b0;
  endtask

  task automatic check_pulse(input string tag, input int idx, input int cyc,
                             input logic [19:0] bcd, input logic s, input logic m);
    if (idx < pq.size()) begin
      check_val({tag, "_cyc"},  32'(pq[idx].cyc), 32'(cyc));
      check_val({tag, "_bcd"},  32'(pq[idx].bcd), 32'(bcd));
      check_val({tag, "_sign"}, 32'(pq[idx].s),   32'(s));
      check_val({tag, "_mode"}, 32'(pq[idx].m),   32'(m));
    end else begin
      check_val({tag, "_present"}, 32'(0), 32'(1));
    end
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    valid_input = 1'b0;
    result_in   = 17'd0;
    mode_in     = 1'b0;
    clear_stim();
    repeat (3) @(negedge clk);
    check_val("rst_bcd",   32'(bcd_out),      32'h0);
    check_val("rst_valid", 32'(valid_output), 32'h0);
    check_val("rst_busy",  32'(busy),         32'h0);
    check_val("rst_drop",  32'(drop_flag),    32'h0);
    reset = 1'b0;

    // Basic positive quotient with latency and busy profile
    clear_stim(); add_stim(0, 26, 1'b1); run(24);
    check_val("p26_count", 32'(pq.size()), 32'd1);
    check_pulse("p26", 0, 18, 20'h00026, 1'b0, 1'b1);
    check_val("p26_busy0",  32'(busy_tr[0]),  32'd0);
    check_val("p26_busy1",  32'(busy_tr[1]),  32'd1);
    check_val("p26_busy19", 32'(busy_tr[19]), 32'd0);
    check_val("p26_drop",   32'(drop_flag),   32'd0);
    check_val("p26_hold",   32'(bcd_out),     32'h00026);
    check_val("p26_vlow",   32'(valid_output), 32'd0);

    clear_stim(); add_stim(0, -26, 1'b0); run(24);
    check_pulse("n26", 0, 18, 20'h00026, 1'b1, 1'b0);

    clear_stim(); add_stim(0, -65536, 1'b1); run(24);
    check_pulse("min", 0, 18, 20'h65536, 1'b1, 1'b1);

    clear_stim(); add_stim(0, 65535, 1'b1); run(24);
    check_pulse("max", 0, 18, 20'h65535, 1'b0, 1'b1);

    clear_stim(); add_stim(0, 0, 1'b0); run(24);
    check_pulse("zero", 0, 18, 20'h00000, 1'b0, 1'b0);

    // Three back-to-back strobes: one converts, one pends, one drops
    clear_stim();
    add_stim(0, 26, 1'b1); add_stim(1, -26, 1'b1); add_stim(2, 26, 1'b1);
    run(45);
    check_val("ovf_count", 32'(pq.size()), 32'd2);
    check_pulse("ovf0", 0, 18, 20'h00026, 1'b0, 1'b1);
    check_pulse("ovf1", 1, 36, 20'h00026, 1'b1, 1'b1);
    check_val("ovf_drop", 32'(drop_flag), 32'd1);

    // Asynchronous reset five cycles into a conversion
    clear_stim(); add_stim(0, 99, 1'b1); run(5);
    #2 reset = 1'b1;
    #1;
    check_val("mrst_bcd",   32'(bcd_out),   32'h0);
    check_val("mrst_sign",  32'(sign_out),  32'h0);
    check_val("mrst_mode",  32'(mode_out),  32'h0);
    check_val("mrst_busy",  32'(busy),      32'h0);
    check_val("mrst_drop",  32'(drop_flag), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_stim(); run(30);
    check_val("mrst_nopulse", 32'(pq.size()), 32'd0);
    clear_stim(); add_stim(0, 13, 1'b0); run(24);
    check_pulse("post_rst", 0, 18, 20'h00013, 1'b0, 1'b0);

    // Strobe on the final CONV edge with pending already occupied
    clear_stim();
    add_stim(0, 100, 1'b1); add_stim(3, 200, 1'b0); add_stim(17, 300, 1'b1);
    run(60);
    check_val("coin_count", 32'(pq.size()), 32'd2);
    check_pulse("coin0", 0, 18, 20'h00100, 1'b0, 1'b1);
    check_pulse("coin1", 1, 36, 20'h00200, 1'b0, 1'b0);
    check_val("coin_drop17", 32'(drop_tr[17]), 32'd0);
    check_val("coin_drop18", 32'(drop_tr[18]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Downstream stage of the divider top level. Captures each 17-bit signed quotient/remainder on the divider's `valid_output` strobe and converts its magnitude to five packed BCD digits plus a sign bit for the board's seven-segment display path. Conversion is sequential double-dabble, one bit per cycle. A one-entry pending buffer absorbs results that arrive while a conversion is in progress; overflow beyond that is dropped and flagged, because the divider has no backpressure.

## Interface
- `RESULT_W`, 17: width of the signed divider result.
- `DIGITS`, 5: BCD digits produced; must satisfy 10^DIGITS > 2^(RESULT_W-1).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; all state and outputs cleared immediately.
- `valid_input` input 1: driven by divider `valid_output`; one-cycle strobe per result.
- `result_in` input RESULT_W: signed divider `final_output`.
- `mode_in` input 1: divider mode tag (1 = quotient, 0 = remainder), carried with the result.
- `bcd_out` output 4*DIGITS: packed BCD magnitude, digit 0 in bits [3:0].
- `sign_out` output 1: 1 when the converted result was negative.
- `mode_out` output 1: `mode_in` captured with the converted result.
- `valid_output` output 1: one-cycle pulse; `bcd_out`/`sign_out`/`mode_out` valid, held until the next pulse.
- `busy` output 1: high in CONV.
- `drop_flag` output 1: sticky; set when a result is discarded; cleared only by reset.

## Operation
- States: IDLE and CONV.
- Reset behaviour: all outputs are 0, pending buffer is empty, and the state is IDLE.
- Capture: the magnitude is `|result_in|`, computed into RESULT_W unsigned bits. For -65536 the magnitude is 65536, so no overflow occurs. The sign is `result_in[RESULT_W-1]`.
- IDLE, source selection at a clock edge:
  - If the pending buffer is full: start from pending, and store any simultaneous `valid_input` into pending.
  - Otherwise, if `valid_input` is high: start from the input.
- Starting a conversion:
  - Load the shift register with the magnitude and clear the BCD accumulator.
  - Set iteration count to 0 and go to CONV.
- CONV, each edge:
  - For every BCD digit ≥ 5, add 3.
  - Then shift {BCD, magnitude} left by 1 and increment the count.
  - On the edge performing iteration RESULT_W: register the final BCD into `bcd_out`, along with `sign_out` and `mode_out`. Pulse `valid_output` and return to IDLE.
- `valid_input` during CONV:
  - Pending empty: store it in pending.
  - Pending full: discard it and set `drop_flag`.
- The `valid_input` that coincides with the final CONV edge follows the CONV rule above.
- The output registers hold their values between pulses. Negative zero cannot occur, since `sign_out` is 0 for a result of 0.

## Timing
- Latency: `valid_input` sampled at edge E0 produces a `valid_output` pulse in the cycle after edge E0+RESULT_W (17 cycles).
- Throughput: one result per RESULT_W+1 = 18 cycles, because one IDLE cycle separates conversions.
- Buffering: up to two results can be absorbed per conversion window (one in progress, one pending). A third arrival in the same window is dropped.
- Reset mid-conversion: the conversion is aborted, no `valid_output` pulse is produced, and pending is cleared.

## Structure
- Shared package `div_pkg`, holding:
  - `RESULT_W`, `DIVIDEND_W` = 32 and `DIVISOR_W` = 16, shared with the divider;
  - `DIGITS`;
  - the state enum {IDLE, CONV}.
- One sub-module, `bcd_digit_adj`: combinational add-3-if-≥5 for a single 4-bit digit, instantiated DIGITS times.

## Test plan
- `result_in` = 26, mode 1, single strobe → after 17 cycles `valid_output` pulses with `bcd_out` = 0x00026, `sign_out` = 0, `mode_out` = 1, `drop_flag` = 0.
- `result_in` = -26, mode 0 → `bcd_out` = 0x00026, `sign_out` = 1, `mode_out` = 0.
- Extremes: `result_in` = -65536 → `bcd_out` = 0x65536, `sign_out` = 1. `result_in` = 65535 → 0x65535, `sign_out` = 0. `result_in` = 0 → 0x00000, `sign_out` = 0.
- Overflow: strobes of 80/3 = 26, then -26 and 26 on the next two cycles → two pulses 18 cycles apart (0x00026 sign 0, then 0x00026 sign 1), the third result is lost, and `drop_flag` = 1.
- Reset mid-conversion: assert `reset` 5 cycles after the strobe → all outputs 0 immediately and no pulse. A fresh strobe of 13 after reset release → 0x00013 after 17 cycles.
- Coincident arrivals: a strobe arriving on the edge CONV finishes, with pending already full → that strobe is dropped and `drop_flag` is set. The pending result starts on the next IDLE edge.
